// File: rtl/pipe_hazard_ctrl_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pipe_hazard_ctrl_if : hazard inputs and pipeline strobes of the controller
// Rev 1.0
// ----------------------------------------------------------------------------
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             id_use_rs1;
  logic             id_use_rs2;
  logic [4:0]       ex_rd;
  logic             ex_regwrite;
  logic             ex_is_load;
  logic             mem_pcsel;
  logic             mem_take_jalr;
  logic [7:0]       mem_jalr_target;
  logic [7:0]       mem_br_target;
  logic             mem_access;
  logic             dmem_ready;

  logic             pc_en;
  logic             if_id_en;
  logic             if_id_flush;
  logic             id_ex_en;
  logic             id_ex_flush;
  logic             ex_mem_en;
  logic             ex_mem_flush;
  logic             mem_wb_flush;
  logic             redirect_valid;
  logic [7:0]       redirect_pc;
  logic             err;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_regwrite, ex_is_load,
           mem_pcsel, mem_take_jalr, mem_jalr_target, mem_br_target, mem_access, dmem_ready,
    input  pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, ex_mem_flush,
           mem_wb_flush, redirect_valid, redirect_pc, err, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_regwrite, ex_is_load,
           mem_pcsel, mem_take_jalr, mem_jalr_target, mem_br_target, mem_access, dmem_ready,
    output pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, ex_mem_flush,
           mem_wb_flush, redirect_valid, redirect_pc, err, stall_cnt, flush_cnt
  );
endinterface
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pipe_hazard_ctrl : 5-stage pipeline stall/flush/redirect controller
// Rev 1.0
// ----------------------------------------------------------------------------
module pipe_hazard_ctrl #(
  parameter int unsigned TIMEOUT = 15,
  parameter int          CNT_W   = 16
) (
  input  wire logic          clk,
  input  wire logic          rst,
  pipe_hazard_ctrl_if.slave  bus
);

  localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [WAIT_W-1:0] WAIT_MAX  = '1;
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_WAIT  = 2'd1,
    S_ERROR = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

  logic       pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush;
  logic       ex_mem_en, ex_mem_flush, mem_wb_flush, redirect_valid;
  logic [7:0] redirect_pc;

  logic mem_stall, redirect, rs1_hit, rs2_hit, load_use;

  assign mem_stall = bus.mem_access & ~bus.dmem_ready;
  assign redirect  = bus.mem_take_jalr | bus.mem_pcsel;
  assign rs1_hit   = bus.id_use_rs1 & (bus.id_rs1 == bus.ex_rd);
  assign rs2_hit   = bus.id_use_rs2 & (bus.id_rs2 == bus.ex_rd);
  assign load_use  = bus.ex_is_load & bus.ex_regwrite & (bus.ex_rd != 5'd0) & (rs1_hit | rs2_hit);

  always_comb begin
    pc_en          = 1'b1;
    if_id_en       = 1'b1;
    id_ex_en       = 1'b1;
    ex_mem_en      = 1'b1;
    if_id_flush    = 1'b0;
    id_ex_flush    = 1'b0;
    ex_mem_flush   = 1'b0;
    mem_wb_flush   = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 8'd0;
    state_d        = state_q;
    wait_cnt_d     = wait_cnt_q;
    err_d          = err_q;

    if (rst) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      ex_mem_en    = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      ex_mem_flush = 1'b1;
      mem_wb_flush = 1'b1;
    end else if (state_q == S_ERROR) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      ex_mem_en    = 1'b0;
      mem_wb_flush = 1'b1;
    end else if (mem_stall) begin
      // Freeze everything upstream of MEM; a pending redirect waits for ready.
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_en     = 1'b0;
      ex_mem_en    = 1'b0;
      mem_wb_flush = 1'b1;
      state_d      = S_WAIT;
      if (wait_cnt_q != WAIT_MAX) wait_cnt_d = wait_cnt_q + WAIT_W'(1);
      if ((state_q == S_WAIT) && (TIMEOUT != 0) && (wait_cnt_q >= WAIT_LAST)) begin
        state_d = S_ERROR;
        err_d   = 1'b1;
      end
    end else begin
      state_d    = S_RUN;
      wait_cnt_d = '0;
      if (redirect) begin
        redirect_valid = 1'b1;
        redirect_pc    = bus.mem_take_jalr ? bus.mem_jalr_target : bus.mem_br_target;
        if_id_flush    = 1'b1;
        id_ex_flush    = 1'b1;
        ex_mem_flush   = 1'b1;
      end else if (load_use) begin
        pc_en       = 1'b0;
        if_id_en    = 1'b0;
        id_ex_flush = 1'b1;
      end
    end

    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!rst && (state_q != S_ERROR)) begin
      if (!pc_en && (stall_cnt_q != CNT_MAX)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
      if (redirect_valid && (flush_cnt_q != CNT_MAX)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_RUN;
      wait_cnt_q  <= '0;
      err_q       <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      err_q       <= err_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign bus.pc_en          = pc_en;
  assign bus.if_id_en       = if_id_en;
  assign bus.if_id_flush    = if_id_flush;
  assign bus.id_ex_en       = id_ex_en;
  assign bus.id_ex_flush    = id_ex_flush;
  assign bus.ex_mem_en      = ex_mem_en;
  assign bus.ex_mem_flush   = ex_mem_flush;
  assign bus.mem_wb_flush   = mem_wb_flush;
  assign bus.redirect_valid = redirect_valid;
  assign bus.redirect_pc    = redirect_pc;
  assign bus.err            = err_q;
  assign bus.stall_cnt      = stall_cnt_q;
  assign bus.flush_cnt      = flush_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_pipe_hazard_ctrl : directed + random bench with a cycle-level reference
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;
  localparam int TIMEOUT = 4;
  localparam int CNT_W   = 4;
  localparam int CMAX    = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.CNT_W(CNT_W)) bus();
  pipe_hazard_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  int compared   = 0;
  int mismatched = 0;

  // Reference state: consecutive stalled cycles, sticky error, event counts.
  int m_nstall = 0;
  bit m_err    = 1'b0;
  int m_stall  = 0;
  int m_flush  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Strobe order: pc_en,if_id_en,if_id_flush,id_ex_en,id_ex_flush,ex_mem_en,ex_mem_flush,mem_wb_flush,redirect_valid
  task automatic cycle(input string tag);
    logic [8:0] exp_s, care, obs_s;
    logic [7:0] exp_pc;
    logic       mstall, redir, lu;
    @(negedge clk);
    mstall = bus.mem_access & ~bus.dmem_ready;
    redir  = bus.mem_take_jalr | bus.mem_pcsel;
    lu     = bus.ex_is_load && bus.ex_regwrite && (bus.ex_rd != 5'd0) &&
             ((bus.id_use_rs1 && bus.id_rs1 == bus.ex_rd) || (bus.id_use_rs2 && bus.id_rs2 == bus.ex_rd));
    care   = 9'h1FF;
    exp_pc = 8'd0;
    if (rst)          exp_s = 9'b001010110;
    else if (m_err)   exp_s = 9'b000000010;
    else if (mstall)  exp_s = 9'b000000010;
    else if (redir) begin
      exp_s  = 9'b111111101;
      exp_pc = bus.mem_take_jalr ? bus.mem_jalr_target : bus.mem_br_target;
    end else if (lu) begin
      exp_s   = 9'b000011000;
      care[5] = 1'b0;
    end else          exp_s = 9'b110101000;
    obs_s = {bus.pc_en, bus.if_id_en, bus.if_id_flush, bus.id_ex_en, bus.id_ex_flush,
             bus.ex_mem_en, bus.ex_mem_flush, bus.mem_wb_flush, bus.redirect_valid};
    check($sformatf("%s/strobes", tag), 32'(obs_s & care), 32'(exp_s & care));
    check($sformatf("%s/redirect_pc", tag), 32'(bus.redirect_pc), 32'(exp_pc));
    check($sformatf("%s/err", tag), 32'(bus.err), 32'(m_err));
    check($sformatf("%s/stall_cnt", tag), 32'(bus.stall_cnt), 32'(m_stall));
    check($sformatf("%s/flush_cnt", tag), 32'(bus.flush_cnt), 32'(m_flush));

    if (rst) begin
      m_nstall = 0; m_err = 1'b0; m_stall = 0; m_flush = 0;
    end else if (!m_err) begin
      if (!exp_s[8] && m_stall < CMAX) m_stall++;
      if (exp_s[0] && m_flush < CMAX) m_flush++;
      if (mstall) begin
        m_nstall++;
        if (TIMEOUT != 0 && m_nstall >= TIMEOUT && m_nstall >= 2) m_err = 1'b1;
      end else begin
        m_nstall = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.id_rs1 = 5'd0; bus.id_rs2 = 5'd0; bus.id_use_rs1 = 1'b0; bus.id_use_rs2 = 1'b0;
    bus.ex_rd = 5'd0; bus.ex_regwrite = 1'b0; bus.ex_is_load = 1'b0;
    bus.mem_pcsel = 1'b0; bus.mem_take_jalr = 1'b0;
    bus.mem_jalr_target = 8'd0; bus.mem_br_target = 8'd0;
    bus.mem_access = 1'b0; bus.dmem_ready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench did not finish");
  end

  initial begin
    idle();
    rst = 1'b1;
    @(posedge clk);
    #1;
    cycle("reset0");
    cycle("reset1");
    rst = 1'b0;
    cycle("post_reset");

    // Load-use on rs2, then the same with x0 as destination
    bus.ex_is_load = 1'b1; bus.ex_regwrite = 1'b1; bus.ex_rd = 5'd5;
    bus.id_rs2 = 5'd5; bus.id_use_rs2 = 1'b1;
    cycle("load_use");
    idle();
    cycle("after_load_use");
    bus.ex_is_load = 1'b1; bus.ex_regwrite = 1'b1; bus.ex_rd = 5'd0;
    bus.id_rs2 = 5'd0; bus.id_use_rs2 = 1'b1;
    cycle("load_use_x0");
    idle();

    // jalr wins over branch
    bus.mem_take_jalr = 1'b1; bus.mem_jalr_target = 8'h40;
    bus.mem_pcsel = 1'b1; bus.mem_br_target = 8'h20;
    cycle("jalr");
    idle();
    cycle("after_jalr");

    // Redirect suppresses a simultaneous load-use
    bus.mem_pcsel = 1'b1; bus.mem_br_target = 8'h33;
    bus.ex_is_load = 1'b1; bus.ex_regwrite = 1'b1; bus.ex_rd = 5'd7;
    bus.id_rs1 = 5'd7; bus.id_use_rs1 = 1'b1;
    cycle("redir_over_lu");
    idle();

    // Three-cycle memory wait
    bus.mem_access = 1'b1; bus.dmem_ready = 1'b0;
    for (int i = 0; i < 3; i++) cycle("mem_wait");
    bus.dmem_ready = 1'b1;
    cycle("mem_ready");
    idle();
    cycle("after_wait");

    // Redirect held across a wait
    bus.mem_pcsel = 1'b1; bus.mem_br_target = 8'h1C;
    bus.mem_access = 1'b1; bus.dmem_ready = 1'b0;
    cycle("redir_wait0");
    cycle("redir_wait1");
    bus.dmem_ready = 1'b1;
    cycle("redir_ready");
    idle();

    // Randomized traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      rst                 = ($urandom_range(0, 99) < 3);
      bus.id_rs1          = 5'($urandom_range(0, 3));
      bus.id_rs2          = 5'($urandom_range(0, 3));
      bus.id_use_rs1      = ($urandom_range(0, 9) < 7);
      bus.id_use_rs2      = ($urandom_range(0, 9) < 7);
      bus.ex_rd           = 5'($urandom_range(0, 3));
      bus.ex_regwrite     = ($urandom_range(0, 9) < 8);
      bus.ex_is_load      = ($urandom_range(0, 1) == 1);
      bus.mem_pcsel       = ($urandom_range(0, 9) < 2);
      bus.mem_take_jalr   = ($urandom_range(0, 9) < 1);
      bus.mem_jalr_target = 8'($urandom);
      bus.mem_br_target   = 8'($urandom);
      bus.mem_access      = ($urandom_range(0, 9) < 5);
      bus.dmem_ready      = ($urandom_range(0, 9) < 5);
      cycle("random");
    end
    rst = 1'b0;
    idle();

    // Watchdog: clear, then hold the memory busy past the limit
    rst = 1'b1;
    cycle("pre_timeout_rst");
    rst = 1'b0;
    bus.mem_access = 1'b1; bus.dmem_ready = 1'b0;
    for (int i = 0; i < 6; i++) cycle("timeout");
    bus.dmem_ready = 1'b1; bus.mem_pcsel = 1'b1; bus.mem_br_target = 8'h55;
    cycle("error_held");
    idle();
    rst = 1'b1;
    cycle("timeout_rst");
    rst = 1'b0;
    cycle("after_timeout_rst");
    bus.mem_pcsel = 1'b1; bus.mem_br_target = 8'h0A;
    cycle("run_again");
    idle();
    cycle("final_idle");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central pipeline controller for the 5-stage core (IF/ID, ID/EX, EX/MEM, MEM/WB registers, 8-bit PC).
- Generates per-register enable and flush strobes and the PC redirect.
- Handles three events: load-use hazards, control transfers resolved in MEM (PCSel / take_jalr carried through EX/MEM), and multi-cycle data-memory waits.
- A timeout watchdog on memory waits, plus saturating stall and flush performance counters.

Parameters:
- TIMEOUT, 15: max consecutive memory-wait cycles before the error state; 0 disables the watchdog.
- CNT_W, 16: width of the performance counters.

Ports:
- clk  input  1  core clock
- rst  input  1  synchronous, active-high reset
- id_rs1  input  5  source register 1 of the instruction in ID
- id_rs2  input  5  source register 2 of the instruction in ID
- id_use_rs1  input  1  ID instruction reads rs1
- id_use_rs2  input  1  ID instruction reads rs2
- ex_rd  input  5  destination register of the instruction in EX
- ex_regwrite  input  1  EX instruction writes the register file
- ex_is_load  input  1  EX instruction is a load (WBSel = memory)
- mem_pcsel  input  1  branch/jal taken, from EX/MEM PCSel_out
- mem_take_jalr  input  1  jalr taken, from EX/MEM take_jalr_out
- mem_jalr_target  input  8  jalr target, from EX/MEM
- mem_br_target  input  8  branch/jal target, from EX/MEM alu_out[7:0]
- mem_access  input  1  MEM stage holds a valid load or store
- dmem_ready  input  1  data memory completes the access this cycle
- pc_en  output  1  PC register load enable
- if_id_en  output  1  IF/ID register enable
- if_id_flush  output  1  IF/ID flush (bubble)
- id_ex_en  output  1  ID/EX register enable
- id_ex_flush  output  1  ID/EX flush
- ex_mem_en  output  1  EX/MEM register enable
- ex_mem_flush  output  1  EX/MEM flush
- mem_wb_flush  output  1  MEM/WB flush (bubble into WB)
- redirect_valid  output  1  PC loads redirect_pc this cycle
- redirect_pc  output  8  redirect target
- err  output  1  sticky memory-timeout error
- stall_cnt  output  CNT_W  cycles with pc_en = 0, excluding the error state
- flush_cnt  output  CNT_W  number of redirects taken

Behaviour:
- Clock and reset: single clock clk. Reset rst is synchronous and active-high.
- On reset:
  - state = RUN; wait_cnt = 0; err = 0; stall_cnt = 0; flush_cnt = 0.
  - While rst is high, the combinational outputs are: all *_en = 0, all *_flush = 1, pc_en = 0, redirect_valid = 0, redirect_pc = 0.
- Timing: strobes are combinational from the registered state and the current inputs (zero latency). State, wait_cnt, err and the counters update on posedge clk.
- States: RUN, WAIT, ERROR.
- Memory stall (highest priority). Condition: mem_access = 1 and dmem_ready = 0, in RUN or WAIT.
  - pc_en, if_id_en, id_ex_en and ex_mem_en are 0; mem_wb_flush = 1; redirect_valid = 0.
  - Next state is WAIT; wait_cnt increments.
  - In WAIT, if TIMEOUT != 0 and wait_cnt == TIMEOUT - 1 while still stalled, next state is ERROR and err is set.
  - When dmem_ready = 1, the pipe advances normally that cycle, wait_cnt clears and next state is RUN.
- Redirect (only when no memory stall). Condition: mem_take_jalr or mem_pcsel.
  - redirect_valid = 1 and pc_en = 1.
  - redirect_pc = mem_jalr_target if mem_take_jalr, else mem_br_target. take_jalr wins if both are set.
  - if_id_flush, id_ex_flush and ex_mem_flush are all 1; all enables are 1.
  - flush_cnt increments.
  - A redirect present during a memory stall is held (the pipe is frozen) and taken on the ready cycle.
- Load-use (only when there is no memory stall and no redirect). Condition: ex_is_load & ex_regwrite & (ex_rd != 0) & ((id_use_rs1 & id_rs1 == ex_rd) | (id_use_rs2 & id_rs2 == ex_rd)).
  - pc_en = 0, if_id_en = 0, id_ex_flush = 1; ex_mem_en = 1.
  - One bubble: the next cycle re-evaluates with the load now in MEM, so the condition drops.
  - A redirect in the same cycle suppresses the load-use stall.
- Default (no event): all enables 1, all flushes 0, redirect_valid = 0, redirect_pc = 0.
- ERROR state:
  - All enables 0; mem_wb_flush = 1; redirect_valid = 0.
  - Held until rst. Counters freeze; err stays 1.
- Counters: saturate at all-ones and never wrap. stall_cnt increments on every non-reset, non-ERROR cycle with pc_en = 0.

Test Plan:
- Reset: rst high for 2 cycles -> stall_cnt = 0, flush_cnt = 0, err = 0. During reset all flushes are 1 and all enables 0. First cycle after reset: all enables 1.
- Load-use: ex_is_load = 1, ex_regwrite = 1, ex_rd = 5, id_rs2 = 5, id_use_rs2 = 1 -> one cycle of pc_en = 0, if_id_en = 0, id_ex_flush = 1, ex_mem_en = 1; stall_cnt = 1. Repeat with ex_rd = 0 -> no stall.
- jalr redirect: mem_take_jalr = 1, mem_jalr_target = 8'h40, mem_pcsel = 1, mem_br_target = 8'h20 -> redirect_pc = 8'h40, three flushes asserted, flush_cnt = 1. In a separate cycle, a load-use condition together with the redirect -> redirect taken, id_ex_en = 1.
- Memory wait: mem_access = 1, dmem_ready = 0 for 3 cycles, then 1 -> 3 frozen cycles with mem_wb_flush = 1; 4th cycle all enables 1; state back to RUN; stall_cnt = 3.
- Redirect during wait: mem_pcsel = 1, mem_br_target = 8'h1C, dmem_ready low for 2 cycles -> redirect_valid = 0 for 2 cycles, then redirect_valid = 1 with redirect_pc = 8'h1C on the ready cycle.
- Timeout: TIMEOUT = 4, dmem_ready held 0 -> err = 1 after the 4th wait cycle. All enables stay 0 and counters freeze until rst; after rst, err = 0 and state = RUN.
